// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encodings and default width.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result bundle between a requester (master) and the serial adder (slave).
interface serial_adder_if
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );

endinterface

// File: rtl/serial_adder_fa.sv
// 1-bit full-adder cell used by the serial adder for per-bit arithmetic.
module serial_adder_fa (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = x ^ y ^ cin;
    assign cout = (x & y) | (x & cin) | (y & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: captures operands on start, adds one bit per clock LSB first,
// and pulses done for one cycle when sum/cout are valid.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_adder_if.slave  bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [WIDTH:0]   sum_ext;
    logic             carry;
    logic             cout_q;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_cout;
    logic             load;
    logic             last;

    serial_adder_fa u_fa (
        .x    (a_sh[0]),
        .y    (b_sh[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_cout)
    );

    assign last    = (cnt == CW'(WIDTH - 1));
    assign sum_ext = {fa_s, sum_sh};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A new start is accepted from IDLE and also from DONE, giving back-to-back operation.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
            cnt    <= '0;
        end else if (load) begin
            a_sh  <= bus.a;
            b_sh  <= bus.b;
            carry <= bus.cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            sum_sh <= sum_ext[WIDTH:1];
            carry  <= fa_cout;
            cnt    <= cnt + CW'(1);
            if (last) begin
                cout_q <= fa_cout;
            end
        end
    end

    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
    assign bus.sum  = sum_sh;
    assign bus.cout = cout_q;

endmodule
